// File: rtl/pu_iteration_controller_pkg.sv
//----------------------------------------------------------------------------
// pu_iteration_controller_pkg - shared state encoding and PU array defaults (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

package pu_iteration_controller_pkg;

  localparam int C_NUM_PU   = 4;
  localparam int C_MAX_ITER = 16;
  localparam int C_ITER_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pu_iteration_controller_if.sv
//----------------------------------------------------------------------------
// pu_iteration_controller_if - start/done handshake and PU array control bus (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

interface pu_iteration_controller_if
  import pu_iteration_controller_pkg::*;
#(
  parameter int NUM_PU = C_NUM_PU,
  parameter int ITER_W = C_ITER_W
) ();

  logic              i_start;
  logic [NUM_PU-1:0] i_pu_zero;
  logic              o_load_en;
  logic              o_compute_en;
  logic              o_busy;
  logic              o_done;
  logic              o_timeout;
  logic [NUM_PU-1:0] o_winner;
  logic [ITER_W-1:0] o_iter_cnt;

  // Controller side
  modport slave (
    input  i_start, i_pu_zero,
    output o_load_en, o_compute_en, o_busy, o_done, o_timeout, o_winner, o_iter_cnt
  );

  // Top-level sequencer / PU array side
  modport master (
    output i_start, i_pu_zero,
    input  o_load_en, o_compute_en, o_busy, o_done, o_timeout, o_winner, o_iter_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pu_iteration_controller_pu_term_detect.sv
//----------------------------------------------------------------------------
// pu_term_detect - counts live PUs; term when at most one survives (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

module pu_term_detect
  import pu_iteration_controller_pkg::*;
#(
  parameter int NUM_PU = C_NUM_PU
) (
  input  wire logic [NUM_PU-1:0] i_pu_zero,
  output logic                   o_term,
  output logic [NUM_PU-1:0]      o_winner
);

  localparam int CW = $clog2(NUM_PU + 1);

  logic [NUM_PU-1:0] w_live;
  logic [CW-1:0]     w_count;

  assign w_live = ~i_pu_zero;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      w_count = w_count + CW'(w_live[i]);
    end
  end

  // With zero or one live PU the live mask is already the one-hot/all-zero winner
  assign o_term   = (w_count <= CW'(1));
  assign o_winner = w_live;

endmodule

`default_nettype wire

// File: rtl/pu_iteration_controller.sv
//----------------------------------------------------------------------------
// pu_iteration_controller - load/compute/check sequencer with iteration budget (rev 1.0)
//----------------------------------------------------------------------------
`default_nettype none

module pu_iteration_controller
  import pu_iteration_controller_pkg::*;
#(
  parameter int NUM_PU   = C_NUM_PU,
  parameter int MAX_ITER = C_MAX_ITER,
  parameter int ITER_W   = C_ITER_W
) (
  input wire logic                  clk,
  input wire logic                  rst,
  pu_iteration_controller_if.slave  bus
);

  localparam logic [ITER_W-1:0] C_ITER_LIMIT = ITER_W'(MAX_ITER);

  state_t            r_state;
  logic              r_load_en;
  logic              r_compute_en;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;
  logic [NUM_PU-1:0] r_winner;
  logic [ITER_W-1:0] r_iter_cnt;

  logic              w_term;
  logic [NUM_PU-1:0] w_winner;

  pu_term_detect #(.NUM_PU(NUM_PU)) u_term_detect (
    .i_pu_zero (bus.i_pu_zero),
    .o_term    (w_term),
    .o_winner  (w_winner)
  );

  // Outputs are set on the edge that enters the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_load_en    <= 1'b0;
      r_compute_en <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_winner     <= '0;
      r_iter_cnt   <= '0;
    end else begin
      r_load_en    <= 1'b0;
      r_compute_en <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state    <= ST_LOAD;
            r_load_en  <= 1'b1;
            r_busy     <= 1'b1;
            r_iter_cnt <= '0;
            r_timeout  <= 1'b0;
            r_winner   <= '0;
          end
        end
        ST_LOAD: begin
          r_state      <= ST_COMPUTE;
          r_compute_en <= 1'b1;
          r_iter_cnt   <= r_iter_cnt + ITER_W'(1);
        end
        ST_COMPUTE: begin
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          // Convergence takes priority over an exhausted budget
          if (w_term) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_winner <= w_winner;
          end else if (r_iter_cnt == C_ITER_LIMIT) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_winner  <= '0;
          end else begin
            r_state      <= ST_COMPUTE;
            r_compute_en <= 1'b1;
            r_iter_cnt   <= r_iter_cnt + ITER_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_load_en    = r_load_en;
  assign bus.o_compute_en = r_compute_en;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_timeout    = r_timeout;
  assign bus.o_winner     = r_winner;
  assign bus.o_iter_cnt   = r_iter_cnt;

endmodule

`default_nettype wire

// File: doc/pu_iteration_controller.md
# pu_iteration_controller

Sequencer for the four-processing-unit iterative datapath. It loads the PUs, then issues one compute step at a time. After each step it samples the PU zero flags and stops when at most one PU is still non-zero (single survivor) or when an iteration budget runs out. It sits between the top-level start/done handshake and the PU array, and replaces free-running termination detection with a registered, cycle-exact control loop.

## Interface
- `NUM_PU`, default 4: number of processing units; one zero flag each.
- `MAX_ITER`, default 16: maximum compute steps before forced stop; must be ≥ 1.
- `ITER_W`, default 5: iteration counter width; must satisfy 2^ITER_W > MAX_ITER.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: level, sampled in IDLE only.
- `pu_zero`, input, NUM_PU: bit i is high when PU i output is zero; valid in the cycle after a compute step.
- `load_en`, output, 1: one-cycle pulse; PUs load initial values.
- `compute_en`, output, 1: one-cycle pulse; PUs perform one iteration.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `timeout`, output, 1: registered; run ended by budget, not convergence.
- `winner`, output, NUM_PU: registered one-hot of the surviving PU; all-zero if every PU is zero or on timeout.
- `iter_cnt`, output, ITER_W: number of compute pulses issued in the current/last run.

## Operation
- States: IDLE, LOAD, COMPUTE, CHECK, DONE.
- IDLE: `start` = 1 moves to LOAD. Otherwise stay.
- LOAD: `load_en` = 1. Clear `iter_cnt`, `timeout` and `winner`. Go to COMPUTE.
- COMPUTE: `compute_en` = 1 and `iter_cnt` += 1. Go to CHECK.
- CHECK: sample `pu_zero` and compute the termination term `term`.
  - `term` = 1 when popcount(~`pu_zero`) ≤ 1.
  - If `term`: `winner` ← ~`pu_zero` (a one-hot or all-zero value); go to DONE.
  - Else if `iter_cnt` == MAX_ITER: `timeout` ← 1, `winner` ← 0; go to DONE.
  - Else go to COMPUTE.
  - If `term` and budget exhaustion happen on the same CHECK, convergence wins: `timeout` = 0.
- DONE: `done` = 1 for exactly one cycle, then IDLE. `winner`, `timeout` and `iter_cnt` hold until the next LOAD.
- `start` while `busy` is ignored. It is not queued.
- `start` held high across DONE immediately begins a new run on the IDLE cycle after DONE.
- `pu_zero` is ignored outside CHECK.

## Timing
- Reset (asynchronous, immediate): state IDLE. All outputs 0: `load_en`, `compute_en`, `busy`, `done`, `timeout`, `winner`, `iter_cnt`.
- Reset mid-run aborts with no `done` pulse.
- Take the `start` sampling edge as cycle 0:
  - cycle 1: LOAD
  - cycle 2: first COMPUTE
  - cycle 3: first CHECK
- A run of N compute steps asserts `done` in cycle 2N+2. The minimum is cycle 4.
- Timeout run: `done` in cycle 2·MAX_ITER+2, with `iter_cnt` = MAX_ITER.
- `load_en` and `compute_en` are never high together and never in consecutive cycles of the same kind. There is at least one CHECK between two compute pulses.
- All outputs are registered or decoded from state only. There is no combinational path from `pu_zero` or `start` to any output.

## Structure
- Shared package/header holds:
  - state encoding constants (IDLE=0, LOAD=1, COMPUTE=2, CHECK=3, DONE=4; 3-bit);
  - the NUM_PU and MAX_ITER defaults, so the PU array and ESG use the same values.
- One sub-module, `pu_term_detect`: combinational popcount of ~`pu_zero` that produces `term` and the `winner` candidate. It is reusable by the ESG.
- The FSM, iteration counter and result registers live in the top module.

## Test plan
- Reset with `start` = 1, released at cycle 0 → all outputs 0 while `rst` is high. LOAD in the first cycle after release.
- Converge in 1 step: `pu_zero` = 4'b0111 at the first CHECK → `done` at cycle 4, `winner` = 4'b1000, `timeout` = 0, `iter_cnt` = 1.
- Converge in 3 steps: `pu_zero` goes 0000 → 0001 → 1101 at successive CHECKs → `done` at cycle 8, `winner` = 4'b0010, `iter_cnt` = 3.
- All zero: `pu_zero` = 4'b1111 at the first CHECK → `done` at cycle 4, `winner` = 0, `timeout` = 0.
- Timeout: MAX_ITER = 4, `pu_zero` held at 0 → `done` at cycle 10, `timeout` = 1, `winner` = 0, `iter_cnt` = 4. Repeat with 4'b1110 arriving on the 4th CHECK → `timeout` = 0, `winner` = 4'b0001.
- Control hazards:
  - `start` pulsed during COMPUTE → ignored, no second LOAD.
  - `rst` asserted during CHECK → IDLE immediately, no `done`.
  - `start` held high → next LOAD two cycles after `done`.
